// File: rtl/bb_row_loader.sv
// Bounding-box window writer: packs raster pixels into a double-buffered H x W window.
// Optional BB_ZERO_PAD_EN: FLUSH seeds (H-1)/2 rows of top zero padding.
module bb_row_loader #(
    parameter int MAC_CN_HGT = 9,
    parameter int BB_WIDTH   = 40,
    parameter int FXP        = 8
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               FLUSH,
    input  logic [FXP-1:0]                     PIX_IN,
    input  logic                               PIX_VALID,
    output logic                               PIX_READY,
    output logic [MAC_CN_HGT*BB_WIDTH*FXP-1:0] BB_OUT,
    output logic                               BB_VALID,
    input  logic                               BB_ACK
);

    localparam int H  = MAC_CN_HGT;
    localparam int W  = BB_WIDTH;
    localparam int P  = (H - 1) / 2;
    localparam int RW = $clog2(H + 1);
    localparam int IW = (H > 1) ? $clog2(H) : 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
`ifdef BB_ZERO_PAD_EN
    localparam int FLUSH_ROWS = P;
`else
    localparam int FLUSH_ROWS = 0;
`endif

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [RW-1:0]  r_rows_cnt;
    logic [RW-1:0]  w_rows_nxt;
    logic [CW-1:0]  r_col_cnt;
    logic           r_stage_full;
    logic [FXP-1:0] r_stage [W];
    logic [FXP-1:0] r_row   [H][W];

    logic           w_ready;
    logic           w_accept;
    logic           w_commit;
    logic           w_shift;
    logic           w_refill;
    logic [IW-1:0]  w_wr_idx;

    assign w_ready   = ~r_stage_full & ~RST;
    assign w_accept  = PIX_VALID & w_ready;
    assign w_wr_idx  = IW'(r_rows_cnt);
    assign PIX_READY = w_ready;
    assign BB_VALID  = (r_state == S_FULL);

    always_comb begin
        w_state_nxt = r_state;
        w_rows_nxt  = r_rows_cnt;
        w_commit    = 1'b0;
        w_shift     = 1'b0;
        w_refill    = 1'b0;
        if (FLUSH) begin
            w_state_nxt = S_FILL;
            w_rows_nxt  = RW'(FLUSH_ROWS);
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (r_stage_full) begin
                        w_commit   = 1'b1;
                        w_rows_nxt = r_rows_cnt + RW'(1);
                        if (r_rows_cnt == RW'(H - 1))
                            w_state_nxt = S_FULL;
                    end
                end
                S_FULL: begin
                    // a staged row keeps the window valid across the slide
                    if (BB_ACK) begin
                        w_shift = 1'b1;
                        if (r_stage_full) begin
                            w_refill = 1'b1;
                        end else begin
                            w_rows_nxt  = RW'(H - 1);
                            w_state_nxt = S_FILL;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_FILL;
            r_rows_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rows_cnt <= w_rows_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col_cnt    <= '0;
            r_stage_full <= 1'b0;
            for (int c = 0; c < W; c++)
                r_stage[c] <= '0;
            for (int j = 0; j < H; j++)
                for (int c = 0; c < W; c++)
                    r_row[j][c] <= '0;
        end else if (FLUSH) begin
            r_col_cnt    <= '0;
            r_stage_full <= 1'b0;
`ifdef BB_ZERO_PAD_EN
            for (int j = 0; j < P; j++)
                for (int c = 0; c < W; c++)
                    r_row[j][c] <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_stage[r_col_cnt] <= PIX_IN;
                if (r_col_cnt == CW'(W - 1)) begin
                    r_col_cnt    <= '0;
                    r_stage_full <= 1'b1;
                end else begin
                    r_col_cnt <= r_col_cnt + CW'(1);
                end
            end
            if (w_commit) begin
                for (int c = 0; c < W; c++)
                    r_row[w_wr_idx][c] <= r_stage[c];
                r_stage_full <= 1'b0;
            end
            if (w_shift) begin
                for (int j = 0; j < H - 1; j++)
                    for (int c = 0; c < W; c++)
                        r_row[j][c] <= r_row[j+1][c];
                if (w_refill) begin
                    for (int c = 0; c < W; c++)
                        r_row[H-1][c] <= r_stage[c];
                    r_stage_full <= 1'b0;
                end
            end
        end
    end

    for (genvar j = 0; j < H; j++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_col
            assign BB_OUT[(j*W+c)*FXP +: FXP] = r_row[j][c];
        end
    end

endmodule

// File: tb/tb_bb_row_loader.sv
// Directed bench for bb_row_loader: fill, back-pressure, slide, flush and padding.
module tb_bb_row_loader;

    localparam int H   = 9;
    localparam int W   = 40;
    localparam int FXP = 8;
`ifdef BB_ZERO_PAD_EN
    localparam int PADR = 4;
`else
    localparam int PADR = 0;
`endif
    localparam int FIRST = (H - PADR) * W;

    logic               CLK = 1'b0;
    logic               RST;
    logic               FLUSH;
    logic [FXP-1:0]     PIX_IN;
    logic               PIX_VALID;
    logic               PIX_READY;
    logic [H*W*FXP-1:0] BB_OUT;
    logic               BB_VALID;
    logic               BB_ACK;

    int n_chk  = 0;
    int n_fail = 0;
    int n_stall;
    int max_stall;
    logic [7:0] exp_w [H][W];

    bb_row_loader #(
        .MAC_CN_HGT (H),
        .BB_WIDTH   (W),
        .FXP        (FXP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (FLUSH),
        .PIX_IN    (PIX_IN),
        .PIX_VALID (PIX_VALID),
        .PIX_READY (PIX_READY),
        .BB_OUT    (BB_OUT),
        .BB_VALID  (BB_VALID),
        .BB_ACK    (BB_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pix(input int j, input int c);
        return BB_OUT[(j*W+c)*FXP +: FXP];
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk_win(input string tag);
        int bad = 0;
        for (int j = 0; j < H; j++)
            for (int c = 0; c < W; c++)
                if (pix(j, c) !== exp_w[j][c]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic set_pat(input int padr, input int off);
        for (int j = 0; j < H; j++)
            for (int c = 0; c < W; c++)
                exp_w[j][c] = (j < padr) ? 8'h00
                            : 8'(((j - padr) * W + c + off) % 256);
    endtask

    task automatic shift_exp(input logic [7:0] v);
        for (int j = 0; j < H - 1; j++)
            for (int c = 0; c < W; c++)
                exp_w[j][c] = exp_w[j+1][c];
        for (int c = 0; c < W; c++)
            exp_w[H-1][c] = v;
    endtask

    task automatic send_px(input logic [7:0] v);
        int t = 0;
        PIX_IN    = v;
        PIX_VALID = 1'b1;
        while (PIX_READY !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) chk("px_ready_wait", PIX_READY, 1);
        n_stall += t;
        if (t > max_stall) max_stall = t;
        @(negedge CLK);
    endtask

    task automatic stream(input int n, input int off, input bit cst,
                          input logic [7:0] v);
        n_stall   = 0;
        max_stall = 0;
        for (int i = 0; i < n; i++)
            send_px(cst ? v : 8'((i + off) % 256));
        PIX_VALID = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        FLUSH     = 1'b0;
        PIX_IN    = '0;
        PIX_VALID = 1'b0;
        BB_ACK    = 1'b0;

        // reset
        tick();
        chk("rst_ready", PIX_READY, 0);
        chk("rst_valid", BB_VALID, 0);
        chk("rst_out_zero", (BB_OUT == '0), 1);
        repeat (2) tick();
        chk("rst_ready_late", PIX_READY, 0);
        RST = 1'b0;
        tick();
        chk("post_rst_ready", PIX_READY, 1);
        chk("post_rst_valid", BB_VALID, 0);

        // first full window
        stream(H * W, 0, 1'b0, 8'h00);
        chk("t2_stalls", n_stall, H - 1);
        chk("t2_max_stall", max_stall, 1);
        chk("t2_valid_e", BB_VALID, 0);
        chk("t2_ready_commit", PIX_READY, 0);
        tick();
        chk("t2_valid_e1", BB_VALID, 1);
        set_pat(0, 0);
        chk_win("t2_win");

        // stage while held, then slide with refill
        stream(W, 0, 1'b1, 8'hA5);
        chk("t3_stalls", n_stall, 0);
        repeat (2) tick();
        chk("t3_backpressure", PIX_READY, 0);
        chk("t3_valid_held", BB_VALID, 1);
        chk_win("t3_hold");
        BB_ACK = 1'b1;
        tick();
        BB_ACK = 1'b0;
        shift_exp(8'hA5);
        chk("t3_valid_cont", BB_VALID, 1);
        chk("t3_row0", pix(0, 0), 40);
        chk("t3_row8", pix(8, 39), 8'hA5);
        chk("t3_ready", PIX_READY, 1);
        chk_win("t3_win");

        // slide with empty stage, ignored ack, refill
        BB_ACK = 1'b1;
        tick();
        BB_ACK = 1'b0;
        chk("t4_drop", BB_VALID, 0);
        shift_exp(8'h3C);
        BB_ACK = 1'b1;
        tick();
        BB_ACK = 1'b0;
        chk("t4_ack_ignored", BB_VALID, 0);
        stream(W, 0, 1'b1, 8'h3C);
        chk("t4_valid_e", BB_VALID, 0);
        tick();
        chk("t4_valid_e1", BB_VALID, 1);
        chk("t4_row8", pix(8, 0), 8'h3C);
        chk_win("t4_win");

        // flush, mid-row flush, fresh window
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("t5_flush_valid", BB_VALID, 0);
        chk("t5_flush_ready", PIX_READY, 1);
        stream(3 * W + 17, 50, 1'b0, 8'h00);
        tick();
        chk("t5_partial_valid", BB_VALID, 0);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        stream(FIRST, 7, 1'b0, 8'h00);
        chk("t5_stalls", n_stall, H - PADR - 1);
        tick();
        chk("t5_valid", BB_VALID, 1);
        set_pat(PADR, 7);
        chk_win("t5_win");

        // flush beats a same-cycle ack and pixel
        FLUSH     = 1'b1;
        BB_ACK    = 1'b1;
        PIX_VALID = 1'b1;
        PIX_IN    = 8'hEE;
        tick();
        FLUSH     = 1'b0;
        BB_ACK    = 1'b0;
        PIX_VALID = 1'b0;
        chk("t5_fa_valid", BB_VALID, 0);
        chk("t5_fa_ready", PIX_READY, 1);
        stream(FIRST - W, 100, 1'b0, 8'h00);
        tick();
        chk("t5_fa_notyet", BB_VALID, 0);
        stream(W, 100 + FIRST - W, 1'b0, 8'h00);
        chk("t5_fa_valid_e", BB_VALID, 0);
        tick();
        chk("t5_fa_valid_e1", BB_VALID, 1);
        set_pat(PADR, 100);
        chk_win("t5_fa_win");

        // 200 pixels after flush
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        stream(200, 3, 1'b0, 8'h00);
        tick();
`ifdef BB_ZERO_PAD_EN
        chk("t6_valid", BB_VALID, 1);
        set_pat(4, 3);
        chk_win("t6_win");
`else
        chk("t6_valid", BB_VALID, 0);
        chk("t6_ready", PIX_READY, 1);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
